// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word-select encoding, default sample geometry and
// the stereo sample pair type used by the player, recorder and this master.
package i2s_pkg;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    localparam int I2S_WIDTH     = 16;
    localparam int I2S_SLOT_BITS = 16;

    typedef struct packed {
        logic [I2S_WIDTH-1:0] left;
        logic [I2S_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock and word-select generator. Divides i_clk down to BCLK, tracks the
// bit position inside the frame and flags the cycle in which BCLK falls.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = I2S_SLOT_BITS
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_en,
    output logic                             o_bclk,
    output logic                             o_lrck,
    output logic                             o_fall_evt,
    output logic [$clog2(2*SLOT_BITS)-1:0]   o_bit_cnt
);

    localparam int CNT_W = $clog2(2*SLOT_BITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2*SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);

    logic [DIV_W-1:0] div_cnt_reg;
    logic             bclk_reg;
    logic             lrck_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             div_tc;

    // Terminal count of the divider and the wrapped next bit position.
    always_comb begin
        div_tc       = (div_cnt_reg == DIV_LAST);
        bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + CNT_W'(1);
    end

    // Divider, BCLK toggle, and bit position / word select advanced on BCLK falls.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_en) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            lrck_reg    <= LR_RIGHT;
            bit_cnt_reg <= BIT_LAST;
        end else if (div_tc) begin
            div_cnt_reg <= '0;
            bclk_reg    <= ~bclk_reg;
            if (bclk_reg) begin
                bit_cnt_reg <= bit_cnt_next;
                lrck_reg    <= (bit_cnt_next >= SLOT_LEN) ? LR_RIGHT : LR_LEFT;
            end
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    assign o_bclk     = bclk_reg;
    assign o_lrck     = lrck_reg;
    assign o_bit_cnt  = bit_cnt_reg;
    assign o_fall_evt = i_en && div_tc && bclk_reg;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: one-pair holding buffer, frame shift register and
// underrun detection on top of the BCLK/LRCK generator.
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int WIDTH     = I2S_WIDTH,
    parameter int SLOT_BITS = I2S_SLOT_BITS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    output logic             o_ready,
    output logic             o_bclk,
    output logic             o_lrck,
    output logic             o_sdata,
    output logic             o_frame,
    output logic             o_underrun,
    output logic [7:0]       o_underrun_cnt
);

    localparam int FRAME_BITS = 2*SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    logic                  fall_evt;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  load_evt;
    logic                  accept;

    logic                  hold_valid_reg;
    logic [WIDTH-1:0]      hold_left_reg;
    logic [WIDTH-1:0]      hold_right_reg;

    logic [SLOT_BITS-1:0]  left_slot;
    logic [SLOT_BITS-1:0]  right_slot;
    logic [FRAME_BITS-1:0] frame_word;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  sdata_reg;
    logic                  frame_reg;
    logic                  underrun_reg;
    logic [7:0]            underrun_cnt_reg;

    i2s_clkgen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clkgen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .o_bclk     (o_bclk),
        .o_lrck     (o_lrck),
        .o_fall_evt (fall_evt),
        .o_bit_cnt  (bit_cnt)
    );

    // The load point is the fall that moves bit_cnt from 0 to 1.
    assign load_evt = fall_evt && (bit_cnt == '0);
    assign accept   = i_valid && !hold_valid_reg;

    // Left-justify each sample in its slot; an empty buffer yields a silent frame.
    always_comb begin
        left_slot  = '0;
        right_slot = '0;
        left_slot[SLOT_BITS-1 -: WIDTH]  = hold_left_reg;
        right_slot[SLOT_BITS-1 -: WIDTH] = hold_right_reg;
        frame_word = hold_valid_reg ? {left_slot, right_slot} : '0;
    end

    // Holding buffer: drained at a load, refilled whenever empty (never both at once).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hold_valid_reg <= 1'b0;
            hold_left_reg  <= '0;
            hold_right_reg <= '0;
        end else if (load_evt && hold_valid_reg) begin
            hold_valid_reg <= 1'b0;
        end else if (accept) begin
            hold_valid_reg <= 1'b1;
            hold_left_reg  <= i_left;
            hold_right_reg <= i_right;
        end
    end

    // Serialiser: the MSB goes straight to the pin at load, the rest is stored
    // pre-shifted so every later fall just emits the register MSB.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shift_reg    <= '0;
            sdata_reg    <= 1'b0;
            frame_reg    <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            frame_reg    <= 1'b0;
            underrun_reg <= 1'b0;
            if (!i_en) begin
                shift_reg <= '0;
                sdata_reg <= 1'b0;
            end else if (load_evt) begin
                shift_reg    <= frame_word << 1;
                sdata_reg    <= frame_word[FRAME_BITS-1];
                frame_reg    <= 1'b1;
                underrun_reg <= !hold_valid_reg;
            end else if (fall_evt) begin
                shift_reg <= shift_reg << 1;
                sdata_reg <= shift_reg[FRAME_BITS-1];
            end
        end
    end

    // Saturating count of frames loaded without data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            underrun_cnt_reg <= 8'd0;
        end else if (load_evt && !hold_valid_reg && (underrun_cnt_reg != 8'hFF)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
        end
    end

    assign o_ready        = !hold_valid_reg;
    assign o_sdata        = sdata_reg;
    assign o_frame        = frame_reg;
    assign o_underrun     = underrun_reg;
    assign o_underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Testbench for i2s_master_tx at CLK_DIV=2, 16-bit samples in 16-bit slots.
// Accepted pairs feed a holding-buffer model; each observed frame load pushes
// the expected frame word, and a serial receiver pops and compares it.
module tb_i2s_master_tx;
    import i2s_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_valid;
    logic [15:0] i_left;
    logic [15:0] i_right;
    logic        o_ready;
    logic        o_bclk;
    logic        o_lrck;
    logic        o_sdata;
    logic        o_frame;
    logic        o_underrun;
    logic [7:0]  o_underrun_cnt;

    i2s_master_tx #(.CLK_DIV(2), .WIDTH(16), .SLOT_BITS(16)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (i_en),
        .i_valid        (i_valid),
        .i_left         (i_left),
        .i_right        (i_right),
        .o_ready        (o_ready),
        .o_bclk         (o_bclk),
        .o_lrck         (o_lrck),
        .o_sdata        (o_sdata),
        .o_frame        (o_frame),
        .o_underrun     (o_underrun),
        .o_underrun_cnt (o_underrun_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs as seen at the most recent rising edge (captured half a cycle earlier).
    logic           p_rst_n = 1'b0;
    logic           p_en    = 1'b0;
    logic           p_valid = 1'b0;
    logic [15:0]    p_left  = '0;
    logic [15:0]    p_right = '0;

    logic           m_hold;
    stereo_sample_t m_pair;
    int             m_cnt;
    logic [31:0]    frame_q[$];

    logic           rx_prev_bclk = 1'b0;
    logic           rx_prev_lrck = 1'b1;
    logic           rx_on        = 1'b0;
    int             rx_n         = 0;
    logic [31:0]    rx_acc       = '0;
    logic [31:0]    last_word    = '0;
    int             rx_count     = 0;
    int             rx_nonzero   = 0;

    // Reference model and serial receiver, evaluated on the falling edge.
    always @(negedge i_clk) begin
        logic        acc;
        logic [31:0] w;
        logic [31:0] e;
        if (!p_rst_n) begin
            m_hold = 1'b0;
            m_pair = '0;
            m_cnt  = 0;
            frame_q.delete();
            rx_on        = 1'b0;
            rx_prev_lrck = 1'b1;
        end else begin
            acc = p_valid && !m_hold;
            if (o_frame) begin
                check_eq("underrun_flag", {31'd0, o_underrun}, {31'd0, !m_hold});
                if (m_hold) begin
                    frame_q.push_back(m_pair);
                    m_hold = 1'b0;
                end else begin
                    frame_q.push_back(32'd0);
                    if (m_cnt < 255) m_cnt++;
                end
                check_eq("underrun_cnt", {24'd0, o_underrun_cnt}, m_cnt);
            end else if (o_underrun) begin
                check_eq("underrun_without_frame", {31'd0, o_underrun}, 32'd0);
            end
            if (acc) begin
                m_hold = 1'b1;
                m_pair = {p_left, p_right};
            end
            if (!p_en) begin
                frame_q.delete();
                rx_on        = 1'b0;
                rx_prev_lrck = 1'b1;
            end else if (o_bclk && !rx_prev_bclk) begin
                if (!o_lrck && rx_prev_lrck) begin
                    if (rx_on) begin
                        w = {rx_acc[30:0], o_sdata};
                        check_eq("rx_bits", rx_n, 31);
                        check_eq("rx_pending", {31'd0, frame_q.size() > 0}, 32'd1);
                        if (frame_q.size() > 0) begin
                            e = frame_q.pop_front();
                            check_eq("rx_frame", w, e);
                        end
                        rx_count++;
                        if (w != 0) begin
                            rx_nonzero++;
                            last_word = w;
                        end
                        $display("frame %0d received %h", rx_count, w);
                    end
                    rx_on  = 1'b1;
                    rx_n   = 0;
                    rx_acc = '0;
                end else if (rx_on) begin
                    rx_acc = {rx_acc[30:0], o_sdata};
                    rx_n++;
                end
                rx_prev_lrck = o_lrck;
            end
        end
        check_eq("ready", {31'd0, o_ready}, {31'd0, !m_hold});
        rx_prev_bclk = o_bclk;
        p_rst_n = i_rst_n;
        p_en    = i_en;
        p_valid = i_valid;
        p_left  = i_left;
        p_right = i_right;
    end

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r, input bit keep);
        int   t;
        logic rdy;
        t = 0;
        @(posedge i_clk); #1;
        i_valid = 1'b1;
        i_left  = l;
        i_right = r;
        do begin
            rdy = o_ready;
            @(posedge i_clk); #1;
            t++;
        end while (!rdy && t < 1000);
        check_eq("send_accept", {31'd0, rdy}, 32'd1);
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int t;
        t = 0;
        @(negedge i_clk);
        while (!o_frame && t < 1000) begin
            @(negedge i_clk);
            t++;
        end
        check_eq(tag, {31'd0, o_frame}, 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        @(negedge i_clk); #1;
        while ((m_hold || frame_q.size() != 0) && t < 3000) begin
            @(negedge i_clk); #1;
            t++;
        end
        check_eq(tag, frame_q.size() + {31'd0, m_hold}, 32'd0);
    endtask

    int exp_bclk[8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
    int exp_lrck[8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    int exp_frame[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        logic [7:0] cnt_before;
        int         nz_before;

        i_rst_n = 1'b0;
        i_en    = 1'b0;
        i_valid = 1'b0;
        i_left  = '0;
        i_right = '0;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_bclk",  {31'd0, o_bclk},  32'd0);
        check_eq("rst_lrck",  {31'd0, o_lrck},  32'd1);
        check_eq("rst_sdata", {31'd0, o_sdata}, 32'd0);
        check_eq("rst_ready", {31'd0, o_ready}, 32'd1);
        check_eq("rst_cnt",   {24'd0, o_underrun_cnt}, 32'd0);

        // Test 1: enable with no data; clock edges and the first underrun.
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_en    = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check_eq($sformatf("t1_bclk_c%0d", n),  {31'd0, o_bclk},  exp_bclk[n-1]);
            check_eq($sformatf("t1_lrck_c%0d", n),  {31'd0, o_lrck},  exp_lrck[n-1]);
            check_eq($sformatf("t1_frame_c%0d", n), {31'd0, o_frame}, exp_frame[n-1]);
            check_eq($sformatf("t1_sdata_c%0d", n), {31'd0, o_sdata}, 32'd0);
        end
        check_eq("t1_underrun", {31'd0, o_underrun}, 32'd1);
        check_eq("t1_cnt", {24'd0, o_underrun_cnt}, 32'd1);

        // Test 2: a single pair, recovered from the serial line.
        send_pair(16'hA5C3, 16'h0F01, 1'b0);
        wait_drain("t2_drain");
        check_eq("t2_word", last_word, 32'hA5C3_0F01);

        // Test 3: sixteen back-to-back pairs with valid held high.
        wait_frame("t3_sync");
        cnt_before = o_underrun_cnt;
        nz_before  = rx_nonzero;
        for (int i = 1; i <= 16; i++) begin
            send_pair(16'(i), 16'h8000 | 16'(i), 1'b1);
        end
        i_valid = 1'b0;
        wait_drain("t3_drain");
        check_eq("t3_frames", rx_nonzero - nz_before, 32'd16);
        check_eq("t3_last", last_word, 32'h0010_8010);
        check_eq("t3_no_underrun", {24'd0, o_underrun_cnt}, {24'd0, cnt_before});

        // Test 4: valid first appears in the load cycle with the buffer empty.
        wait_frame("t4_sync");
        repeat (255) @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_left  = 16'h1234;
        i_right = 16'h5678;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        check_eq("t4_frame",    {31'd0, o_frame},    32'd1);
        check_eq("t4_underrun", {31'd0, o_underrun}, 32'd1);
        check_eq("t4_ready",    {31'd0, o_ready},    32'd0);
        wait_drain("t4_drain");
        check_eq("t4_word", last_word, 32'h1234_5678);

        // Test 5: disable mid left slot with a pair buffered, then resume.
        wait_frame("t5_sync");
        send_pair(16'hBEEF, 16'h4321, 1'b0);
        repeat (24) @(posedge i_clk);
        check_eq("t5_left_slot", {31'd0, o_lrck}, 32'd0);
        #1;
        i_en = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check_eq("t5_bclk",  {31'd0, o_bclk},  32'd0);
        check_eq("t5_lrck",  {31'd0, o_lrck},  32'd1);
        check_eq("t5_sdata", {31'd0, o_sdata}, 32'd0);
        repeat (20) @(posedge i_clk);
        check_eq("t5_hold_kept", {31'd0, o_ready}, 32'd0);
        cnt_before = o_underrun_cnt;
        #1;
        i_en = 1'b1;
        wait_drain("t5_drain");
        check_eq("t5_word", last_word, 32'hBEEF_4321);
        check_eq("t5_no_underrun", {24'd0, o_underrun_cnt}, {24'd0, cnt_before});

        // Test 6: saturate the underrun counter, then a one-cycle reset.
        for (int f = 0; f < 260; f++) begin
            wait_frame("t6_frame");
        end
        check_eq("t6_saturated", {24'd0, o_underrun_cnt}, 32'd255);
        send_pair(16'h0F0F, 16'hF0F0, 1'b0);
        @(negedge i_clk);
        check_eq("t6_full", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_eq("t6_bclk",     {31'd0, o_bclk},     32'd0);
        check_eq("t6_lrck",     {31'd0, o_lrck},     32'd1);
        check_eq("t6_sdata",    {31'd0, o_sdata},    32'd0);
        check_eq("t6_frame",    {31'd0, o_frame},    32'd0);
        check_eq("t6_underrun", {31'd0, o_underrun}, 32'd0);
        check_eq("t6_ready",    {31'd0, o_ready},    32'd1);
        check_eq("t6_cnt",      {24'd0, o_underrun_cnt}, 32'd0);

        @(posedge i_clk); #1;
        i_en = 1'b0;
        repeat (4) @(posedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
